// File: rtl/dma_csr_pkg.sv
// ============================================================================
// Module      : dma_csr_pkg
// Description : Shared types and constants for the DMA CSR master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dma_csr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GAP    = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [1:0] RSP_OK       = 2'b00;
    localparam logic [1:0] RSP_TIMEOUT  = 2'b01;
    localparam logic [1:0] RSP_POLL_EXH = 2'b10;

    localparam logic [3:0] REG_STATUS   = 4'h0;
    localparam logic [3:0] REG_CONTROL  = 4'h4;
    localparam logic [3:0] REG_NEXT_PTR = 4'h8;

    function automatic logic poll_match(input logic [31:0] rdata,
                                        input logic [31:0] exp_v,
                                        input logic [31:0] mask);
        return ((rdata ^ exp_v) & mask) == 32'h0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_csr_mst_cnt.sv
// ============================================================================
// Module      : dma_csr_mst_cnt
// Description : Loadable, clearable saturating down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_csr_mst_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/dma_csr_master.sv
// ============================================================================
// Module      : dma_csr_master
// Description : Command-driven CSR bus master with wait, timeout and polling.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_csr_master
    import dma_csr_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int POLL_MAX       = 16,
    parameter int POLL_GAP       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic        cmd_poll_i,
    input  logic [3:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_be_i,
    input  logic [31:0] cmd_mask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_status_o,
    output logic        csr_wr_o,
    output logic        csr_rd_o,
    output logic [3:0]  csr_addr_o,
    output logic [31:0] csr_wr_data_o,
    output logic [3:0]  csr_be_o,
    input  logic        csr_wait_rq_i,
    input  logic [31:0] csr_rd_data_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + POLL_GAP + 1);
    localparam int RD_W  = $clog2(POLL_MAX + 1);
    localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(POLL_GAP - 1);
    localparam logic [RD_W-1:0]  POLL_LAST = RD_W'(POLL_MAX - 1);

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              write_q, write_d;
    logic              poll_q, poll_d;
    logic [31:0]       mask_q, mask_d;
    logic [31:0]       exp_q, exp_d;
    logic              csr_wr_q, csr_wr_d;
    logic              csr_rd_q, csr_rd_d;
    logic [3:0]        csr_addr_q, csr_addr_d;
    logic [31:0]       csr_wr_data_q, csr_wr_data_d;
    logic [3:0]        csr_be_q, csr_be_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic [RD_W-1:0]   reads_q, reads_d;

    logic              cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_load_val;

    // One counter times both the wait limit in ACCESS and the idle span in GAP;
    // each state reloads it on entry, so the two uses never overlap.
    dma_csr_mst_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        write_d       = write_q;
        poll_d        = poll_q;
        mask_d        = mask_q;
        exp_d         = exp_q;
        csr_wr_d      = csr_wr_q;
        csr_rd_d      = csr_rd_q;
        csr_addr_d    = csr_addr_q;
        csr_wr_data_d = csr_wr_data_q;
        csr_be_d      = csr_be_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_status_d  = rsp_status_q;
        reads_d       = reads_q;
        cnt_clr       = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        cnt_load_val  = TO_LOAD;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d   = 1'b0;
                    write_d       = cmd_write_i;
                    poll_d        = cmd_poll_i & ~cmd_write_i;
                    mask_d        = cmd_mask_i;
                    exp_d         = cmd_wdata_i;
                    csr_wr_d      = cmd_write_i;
                    csr_rd_d      = ~cmd_write_i;
                    csr_addr_d    = cmd_addr_i;
                    csr_wr_data_d = cmd_write_i ? cmd_wdata_i : 32'h0;
                    csr_be_d      = cmd_write_i ? cmd_be_i : 4'hF;
                    rsp_rdata_d   = 32'h0;
                    rsp_status_d  = RSP_OK;
                    reads_d       = '0;
                    cnt_load      = 1'b1;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!csr_wait_rq_i) begin
                    csr_wr_d = 1'b0;
                    csr_rd_d = 1'b0;
                    if (write_q) begin
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        rsp_rdata_d = csr_rd_data_i;
                        reads_d     = reads_q + RD_W'(1);
                        if (!poll_q || poll_match(csr_rd_data_i, exp_q, mask_q)) begin
                            rsp_valid_d = 1'b1;
                            state_d     = ST_RESP;
                        end else if (reads_q == POLL_LAST) begin
                            rsp_status_d = RSP_POLL_EXH;
                            rsp_valid_d  = 1'b1;
                            state_d      = ST_RESP;
                        end else begin
                            cnt_load     = 1'b1;
                            cnt_load_val = GAP_LOAD;
                            state_d      = ST_GAP;
                        end
                    end
                end else if (cnt_zero) begin
                    // Zero here means TIMEOUT_CYCLES waited cycles have elapsed.
                    csr_wr_d     = 1'b0;
                    csr_rd_d     = 1'b0;
                    rsp_rdata_d  = 32'h0;
                    rsp_status_d = RSP_TIMEOUT;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    csr_rd_d = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = ST_ACCESS;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    cnt_clr     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            write_q       <= 1'b0;
            poll_q        <= 1'b0;
            mask_q        <= 32'h0;
            exp_q         <= 32'h0;
            csr_wr_q      <= 1'b0;
            csr_rd_q      <= 1'b0;
            csr_addr_q    <= 4'h0;
            csr_wr_data_q <= 32'h0;
            csr_be_q      <= 4'h0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_status_q  <= RSP_OK;
            reads_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            write_q       <= write_d;
            poll_q        <= poll_d;
            mask_q        <= mask_d;
            exp_q         <= exp_d;
            csr_wr_q      <= csr_wr_d;
            csr_rd_q      <= csr_rd_d;
            csr_addr_q    <= csr_addr_d;
            csr_wr_data_q <= csr_wr_data_d;
            csr_be_q      <= csr_be_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_status_q  <= rsp_status_d;
            reads_q       <= reads_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign csr_wr_o      = csr_wr_q;
    assign csr_rd_o      = csr_rd_q;
    assign csr_addr_o    = csr_addr_q;
    assign csr_wr_data_o = csr_wr_data_q;
    assign csr_be_o      = csr_be_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_status_o  = rsp_status_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_csr_master.sv
// ============================================================================
// Module      : tb_dma_csr_master
// Description : Scoreboard bench for dma_csr_master with a scripted responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dma_csr_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_write_i = 1'b0;
    logic        cmd_poll_i = 1'b0;
    logic [3:0]  cmd_addr_i = 4'h0;
    logic [31:0] cmd_wdata_i = 32'h0;
    logic [3:0]  cmd_be_i = 4'h0;
    logic [31:0] cmd_mask_i = 32'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_status_o;
    logic        csr_wr_o;
    logic        csr_rd_o;
    logic [3:0]  csr_addr_o;
    logic [31:0] csr_wr_data_o;
    logic [3:0]  csr_be_o;
    logic        csr_wait_rq_i = 1'b0;
    logic [31:0] csr_rd_data_i = 32'h0;

    always #5 clk = ~clk;

    dma_csr_master #(
        .TIMEOUT_CYCLES (8),
        .POLL_MAX       (16),
        .POLL_GAP       (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_write_i   (cmd_write_i),
        .cmd_poll_i    (cmd_poll_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .cmd_be_i      (cmd_be_i),
        .cmd_mask_i    (cmd_mask_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_status_o  (rsp_status_o),
        .csr_wr_o      (csr_wr_o),
        .csr_rd_o      (csr_rd_o),
        .csr_addr_o    (csr_addr_o),
        .csr_wr_data_o (csr_wr_data_o),
        .csr_be_o      (csr_be_o),
        .csr_wait_rq_i (csr_wait_rq_i),
        .csr_rd_data_i (csr_rd_data_i)
    );

    typedef struct {
        logic [1:0]  st;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;

    // Responder script, written only by the test tasks
    int          wait_n = 0;
    int          wf_idx = 1000;
    int          rd_base = 0;
    logic [31:0] rd_seq [0:31];

    // Bus monitor state, written only by the monitor
    int          cyc = 0;
    int          wr_hi = 0, rd_hi = 0, both_hi = 0, rsp_hi = 0;
    int          n_start = 0, n_end = 0;
    int          rd_start [0:255];
    int          rd_end [0:255];
    logic        prev_rd = 1'b0;
    int          req_idx = 0;

    // Wait is held for wait_n request cycles; reads from index wf_idx wait forever.
    always @(negedge clk) begin
        if (csr_wr_o || csr_rd_o) begin
            if (csr_rd_o && ((n_end - rd_base) >= wf_idx))
                csr_wait_rq_i = 1'b1;
            else
                csr_wait_rq_i = (req_idx < wait_n);
            csr_rd_data_i = rd_seq[(n_end - rd_base) & 31];
            req_idx = req_idx + 1;
        end else begin
            req_idx = 0;
            csr_wait_rq_i = 1'b0;
            csr_rd_data_i = 32'h0;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (csr_wr_o) wr_hi <= wr_hi + 1;
        if (csr_rd_o) rd_hi <= rd_hi + 1;
        if (csr_wr_o && csr_rd_o) both_hi <= both_hi + 1;
        if (rsp_valid_o) rsp_hi <= rsp_hi + 1;
        if (csr_rd_o && !prev_rd && n_start < 256) begin
            rd_start[n_start] <= cyc;
            n_start <= n_start + 1;
        end
        if (csr_rd_o && !csr_wait_rq_i && n_end < 256) begin
            rd_end[n_end] <= cyc;
            n_end <= n_end + 1;
        end
        prev_rd <= csr_rd_o;
    end

    task automatic issue(input logic wr, input logic pl, input logic [3:0] ad,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] mk, output int t);
        int k;
        @(negedge clk);
        cmd_write_i = wr;
        cmd_poll_i  = pl;
        cmd_addr_i  = ad;
        cmd_wdata_i = wd;
        cmd_be_i    = be;
        cmd_mask_i  = mk;
        cmd_valid_i = 1'b1;
        k = 0;
        while (!cmd_ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (!cmd_ready_o) begin
            fails++;
            $display("FAIL issue_ready: cmd_ready_o=%0b required 1 within 50 cycles", cmd_ready_o);
        end
        t = cyc;
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int lim, output int tr);
        int k;
        k = 0;
        while (!rsp_valid_o && k < lim) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (!rsp_valid_o) begin
            fails++;
            $display("FAIL rsp_wait: rsp_valid_o=%0b required 1 within %0d cycles", rsp_valid_o, lim);
        end
        tr = cyc;
    endtask

    task automatic ack_rsp();
        rsp_ready_i = 1'b1;
        @(negedge clk);
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [77:0] snap;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        snap = {csr_wr_o, csr_rd_o, rsp_valid_o, cmd_ready_o, csr_addr_o,
                csr_wr_data_o, csr_be_o, rsp_rdata_o, rsp_status_o};
        tests++;
        if (snap !== 78'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0", snap);
        end
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (cmd_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: cmd_ready_o=%0b required 1", cmd_ready_o);
        end
    endtask

    task automatic test_write();
        int t, tr, w0;
        exp_t e;
        wait_n = 1;
        wf_idx = 1000;
        w0 = wr_hi;
        sb.push_back('{2'b00, 32'h0});
        issue(1'b1, 1'b0, 4'h4, 32'hA5A5_0001, 4'hF, 32'h0, t);
        tests++;
        if (csr_wr_o !== 1'b1 || csr_rd_o !== 1'b0 || csr_addr_o !== 4'h4 ||
            csr_wr_data_o !== 32'hA5A5_0001 || csr_be_o !== 4'hF) begin
            fails++;
            $display("FAIL wr_bus: wr=%0b rd=%0b addr=%h data=%h be=%h required 1 0 4 a5a50001 f",
                     csr_wr_o, csr_rd_o, csr_addr_o, csr_wr_data_o, csr_be_o);
        end
        wait_rsp(20, tr);
        tests++;
        if (tr - t !== 3) begin
            fails++;
            $display("FAIL wr_latency: rsp at T+%0d required T+3", tr - t);
        end
        tests++;
        if (wr_hi - w0 !== 2) begin
            fails++;
            $display("FAIL wr_cycles: csr_wr_o high %0d cycles required 2", wr_hi - w0);
        end
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL wr_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (rsp_status_o !== e.st || rsp_rdata_o !== e.rd) begin
                fails++;
                $display("FAIL wr_rsp: status=%b rdata=%h required %b %h", rsp_status_o, rsp_rdata_o, e.st, e.rd);
            end
        end
        ack_rsp();
    endtask

    task automatic test_read();
        int t, tr;
        exp_t e;
        wait_n = 2;
        rd_base = n_end;
        rd_seq[0] = 32'h0000_1000;
        sb.push_back('{2'b00, 32'h0000_1000});
        issue(1'b0, 1'b0, 4'h8, 32'hDEAD_BEEF, 4'h3, 32'h0, t);
        tests++;
        if (csr_rd_o !== 1'b1 || csr_wr_o !== 1'b0 || csr_be_o !== 4'hF || csr_addr_o !== 4'h8) begin
            fails++;
            $display("FAIL rd_bus: rd=%0b wr=%0b be=%h addr=%h required 1 0 f 8", csr_rd_o, csr_wr_o, csr_be_o, csr_addr_o);
        end
        wait_rsp(20, tr);
        tests++;
        if (tr - t !== 4) begin
            fails++;
            $display("FAIL rd_latency: rsp at T+%0d required T+4", tr - t);
        end
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL rd_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (rsp_status_o !== e.st || rsp_rdata_o !== e.rd) begin
                fails++;
                $display("FAIL rd_rsp: status=%b rdata=%h required %b %h", rsp_status_o, rsp_rdata_o, e.st, e.rd);
            end
        end
        repeat (2) @(negedge clk);
        tests++;
        if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0000_1000 || rsp_status_o !== 2'b00) begin
            fails++;
            $display("FAIL rd_hold: valid=%0b rdata=%h status=%b required 1 00001000 00", rsp_valid_o, rsp_rdata_o, rsp_status_o);
        end
        ack_rsp();
    endtask

    task automatic test_poll_match();
        int t, tr, s0, e0;
        exp_t e;
        wait_n = 0;
        rd_base = n_end;
        rd_seq[0] = 32'hFFFF_0000;
        rd_seq[1] = 32'h1234_0002;
        rd_seq[2] = 32'hABCD_0001;
        s0 = n_start;
        e0 = n_end;
        sb.push_back('{2'b00, 32'hABCD_0001});
        issue(1'b0, 1'b1, 4'h0, 32'h1, 4'h0, 32'h1, t);
        wait_rsp(100, tr);
        tests++;
        if (n_end - e0 !== 3) begin
            fails++;
            $display("FAIL poll_reads: %0d reads required 3", n_end - e0);
        end
        for (int i = 1; i < 3; i++) begin
            tests++;
            if (rd_start[s0 + i] - rd_end[e0 + i - 1] - 1 !== 4) begin
                fails++;
                $display("FAIL poll_gap%0d: %0d idle cycles required 4", i, rd_start[s0 + i] - rd_end[e0 + i - 1] - 1);
            end
        end
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL poll_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (rsp_status_o !== e.st || rsp_rdata_o !== e.rd) begin
                fails++;
                $display("FAIL poll_rsp: status=%b rdata=%h required %b %h", rsp_status_o, rsp_rdata_o, e.st, e.rd);
            end
        end
        ack_rsp();
    endtask

    task automatic test_poll_exhaust();
        int t, tr, e0;
        exp_t e;
        wait_n = 1;
        rd_base = n_end;
        for (int i = 0; i < 32; i++) rd_seq[i] = 32'h100 + 32'(2 * i);
        e0 = n_end;
        sb.push_back('{2'b10, 32'h0000_011E});
        issue(1'b0, 1'b1, 4'h0, 32'h1, 4'h0, 32'h1, t);
        wait_rsp(400, tr);
        tests++;
        if (n_end - e0 !== 16) begin
            fails++;
            $display("FAIL exh_reads: %0d reads required 16", n_end - e0);
        end
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL exh_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (rsp_status_o !== e.st || rsp_rdata_o !== e.rd) begin
                fails++;
                $display("FAIL exh_rsp: status=%b rdata=%h required %b %h", rsp_status_o, rsp_rdata_o, e.st, e.rd);
            end
        end
        ack_rsp();
    endtask

    task automatic test_timeout();
        int t, tr, r0;
        exp_t e;
        wait_n = 0;
        rd_base = n_end;
        wf_idx = 0;
        rd_seq[0] = 32'h7777_7777;
        r0 = rd_hi;
        sb.push_back('{2'b01, 32'h0});
        issue(1'b0, 1'b0, 4'h8, 32'h0, 4'h0, 32'h0, t);
        repeat (7) @(negedge clk);
        tests++;
        if (csr_rd_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL to_t8: rd=%0b valid=%0b required 1 0", csr_rd_o, rsp_valid_o);
        end
        @(negedge clk);
        tests++;
        if (csr_rd_o !== 1'b0 || rsp_valid_o !== 1'b1 || rd_hi - r0 !== 8) begin
            fails++;
            $display("FAIL to_drop: rd=%0b valid=%0b rd_cycles=%0d required 0 1 8", csr_rd_o, rsp_valid_o, rd_hi - r0);
        end
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL to_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (rsp_status_o !== e.st || rsp_rdata_o !== e.rd) begin
                fails++;
                $display("FAIL to_rsp: status=%b rdata=%h required %b %h", rsp_status_o, rsp_rdata_o, e.st, e.rd);
            end
        end
        ack_rsp();
        // Poll whose second read stalls: the first read's data must not leak out.
        rd_base = n_end;
        wf_idx = 1;
        rd_seq[0] = 32'h0000_0010;
        sb.push_back('{2'b01, 32'h0});
        issue(1'b0, 1'b1, 4'h0, 32'h1, 4'h0, 32'h1, t);
        wait_rsp(60, tr);
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL pto_sb: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (rsp_status_o !== e.st || rsp_rdata_o !== e.rd) begin
                fails++;
                $display("FAIL pto_rsp: status=%b rdata=%h required %b %h", rsp_status_o, rsp_rdata_o, e.st, e.rd);
            end
        end
        ack_rsp();
        wf_idx = 1000;
    endtask

    task automatic test_back_to_back();
        int t, tr;
        exp_t e;
        wait_n = 0;
        rd_base = n_end;
        rd_seq[0] = 32'h55AA_0000;
        sb.push_back('{2'b00, 32'h55AA_0000});
        issue(1'b0, 1'b1, 4'h8, 32'h0, 4'h0, 32'h0, t);
        wait_rsp(20, tr);
        tests++;
        if (cmd_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ready_resp: cmd_ready_o=%0b required 0", cmd_ready_o);
        end
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL b2b_sb1: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (rsp_status_o !== e.st || rsp_rdata_o !== e.rd) begin
                fails++;
                $display("FAIL b2b_rsp1: status=%b rdata=%h required %b %h", rsp_status_o, rsp_rdata_o, e.st, e.rd);
            end
        end
        ack_rsp();
        tests++;
        if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b_ready_idle: ready=%0b valid=%0b required 1 0", cmd_ready_o, rsp_valid_o);
        end
        sb.push_back('{2'b00, 32'h0});
        issue(1'b1, 1'b1, 4'h8, 32'h0000_2000, 4'h3, 32'h0, t);
        tests++;
        if (csr_wr_o !== 1'b1 || csr_rd_o !== 1'b0 || csr_be_o !== 4'h3) begin
            fails++;
            $display("FAIL b2b_wr_bus: wr=%0b rd=%0b be=%h required 1 0 3", csr_wr_o, csr_rd_o, csr_be_o);
        end
        wait_rsp(20, tr);
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $display("FAIL b2b_sb2: scoreboard empty");
        end else begin
            e = sb.pop_front();
            if (rsp_status_o !== e.st || rsp_rdata_o !== e.rd) begin
                fails++;
                $display("FAIL b2b_rsp2: status=%b rdata=%h required %b %h", rsp_status_o, rsp_rdata_o, e.st, e.rd);
            end
        end
        ack_rsp();
        tests++;
        if (both_hi !== 0) begin
            fails++;
            $display("FAIL wr_rd_overlap: %0d cycles with both high required 0", both_hi);
        end
    endtask

    task automatic test_reset_mid_access();
        int t, r0;
        logic [77:0] snap;
        wait_n = 1000;
        issue(1'b1, 1'b0, 4'h8, 32'h1234_5678, 4'hF, 32'h0, t);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        snap = {csr_wr_o, csr_rd_o, rsp_valid_o, cmd_ready_o, csr_addr_o,
                csr_wr_data_o, csr_be_o, rsp_rdata_o, rsp_status_o};
        tests++;
        if (snap !== 78'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %h required 0", snap);
        end
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (cmd_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset_ready: cmd_ready_o=%0b required 1", cmd_ready_o);
        end
        r0 = rsp_hi;
        repeat (10) @(negedge clk);
        tests++;
        if (rsp_hi !== r0 || rsp_valid_o !== 1'b0 || csr_wr_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_norsp: rsp cycles=%0d valid=%0b wr=%0b required 0 0 0", rsp_hi - r0, rsp_valid_o, csr_wr_o);
        end
        wait_n = 0;
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL sb_leftover: %0d entries required 0", sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rd_seq[i] = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_poll_match();
        test_poll_exhaust();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dma_csr_master.md
DMA_CSR_MASTER -- requirements
Module: dma_csr_master

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, default 256, the maximum number of cycles an access may be waited before it is aborted.
REQ-002 Parameters SHALL be: POLL_MAX, default 16, the maximum number of reads in one poll command.
REQ-003 Parameters SHALL be: POLL_GAP, default 4, the number of idle cycles between poll reads.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
REQ-005 Ports SHALL be (command side):
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_poll_i  in  1  poll-until-match (reads only)
- cmd_addr_i  in  4  register offset
- cmd_wdata_i  in  32  write data, or poll expected value
- cmd_be_i  in  4  byte enables (writes)
- cmd_mask_i  in  32  poll compare mask
REQ-006 Ports SHALL be (response side):
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  32  last read data
- rsp_status_o  out  2  00 OK, 01 timeout, 10 poll exhausted
REQ-007 Ports SHALL be (CSR bus):
- csr_wr_o  out  1  write request
- csr_rd_o  out  1  read request
- csr_addr_o  out  4  address
- csr_wr_data_o  out  32  write data
- csr_be_o  out  4  byte enables
- csr_wait_rq_i  in  1  responder wait request
- csr_rd_data_i  in  32  read data

Function
REQ-008 The FSM SHALL have the states IDLE, ACCESS, GAP and RESP, and all outputs SHALL be registered.
REQ-009 cmd_ready_o SHALL be 1 only in IDLE; a command is accepted in the cycle where cmd_valid_i and cmd_ready_o are both 1, and all command fields SHALL be latched at that point.
REQ-010 In ACCESS, exactly one of csr_wr_o or csr_rd_o SHALL be high, and csr_addr_o, csr_wr_data_o and csr_be_o SHALL be held stable.
REQ-011 csr_be_o SHALL be 4'hF for reads.
REQ-012 An access SHALL complete in the first ACCESS cycle in which csr_wait_rq_i is 0.
- On that edge, csr_wr_o and csr_rd_o SHALL deassert.
- For a read, csr_rd_data_i SHALL be captured into rsp_rdata_o on that edge.
REQ-013 Timing: if the command is accepted in cycle T, the request SHALL be high from T+1. If completion occurs in cycle W, rsp_valid_o SHALL be high from W+1.
REQ-014 A timeout counter SHALL count ACCESS cycles in which csr_wait_rq_i is 1.
- When the count reaches TIMEOUT_CYCLES, the request SHALL drop and the FSM SHALL enter RESP with status 01.
- rsp_rdata_o SHALL be 0 in that case.
- The counter SHALL clear on entry to ACCESS.
REQ-015 A poll command SHALL repeat reads until (rdata & cmd_mask) == (cmd_wdata & cmd_mask).
- On a match, the FSM SHALL enter RESP with status 00.
- On a mismatch with reads < POLL_MAX, the FSM SHALL enter GAP for POLL_GAP cycles, then return to ACCESS.
- On the POLL_MAX-th mismatch, the FSM SHALL enter RESP with status 10 and the last rdata.
REQ-016 A timeout during a poll SHALL end the command with status 01.
REQ-017 cmd_poll_i SHALL be ignored when cmd_write_i is 1.
REQ-018 rsp_valid_o SHALL remain high in RESP, with rsp_* held, until rsp_ready_i is 1; the FSM then returns to IDLE on that edge. A new command is accepted no earlier than the following cycle.
REQ-019 A write response SHALL have status 00 and rsp_rdata_o 0.
REQ-020 csr_wr_o and csr_rd_o SHALL never be high in the same cycle, and SHALL never be high outside ACCESS.

Reset
REQ-021 When reset_n is 0 at an edge, the block SHALL enter IDLE and drive:
- csr_wr_o, csr_rd_o, rsp_valid_o = 0
- cmd_ready_o = 0 during reset, 1 in the first cycle after reset
- csr_addr_o = 0, csr_wr_data_o = 0, csr_be_o = 0
- rsp_rdata_o = 0, rsp_status_o = 0
- all counters = 0
REQ-022 Reset during ACCESS, GAP or RESP SHALL discard the in-flight command without producing a response.

Structure
REQ-023 The package dma_csr_pkg SHALL hold:
- the state encoding
- the rsp_status codes
- the register offsets CONTROL = 4'h4, STATUS = 4'h0, NEXT_PTR = 4'h8
REQ-024 One sub-module, dma_csr_mst_cnt, SHALL provide a loadable, clearable down-counter, shared by the timeout and GAP timing.

Verification
REQ-025 The bench SHALL cover a write to 4'h4 with data 0xA5A5_0001 and be 4'hF, against a responder that drops wait on the 2nd request cycle: csr_wr_o is high for 2 cycles, rsp_valid_o rises at T+3, and status is 00.
REQ-026 The bench SHALL cover a read of 4'h8 with the responder returning 0x0000_1000 with wait low on the 3rd cycle: rsp_rdata_o = 0x0000_1000 at T+4, and csr_be_o = 4'hF.
REQ-027 The bench SHALL cover a poll of 4'h0 with mask 0x1 and expected value 0x1, where the responder returns 0x0 twice then 0x1: 3 reads, with a 4-cycle gap between reads, and status 00.
REQ-028 The bench SHALL cover a poll that never matches: exactly 16 reads, then status 10 with the last rdata.
REQ-029 The bench SHALL cover TIMEOUT_CYCLES = 8 with wait held high: the request drops after 8 waited cycles, status is 01, and rdata is 0.
REQ-030 The bench SHALL cover reset_n pulsed low mid-ACCESS: all outputs are 0 at the next edge, no response is produced, and cmd_ready_o is 1 in the first cycle after reset.
